// File: rtl/game_turn_controller.sv
// Tic-tac-toe turn sequencer: validates a placement, writes the mover's symbol,
// scans the eight win lines one per cycle, then resolves win/draw or passes the turn.
module game_turn_controller #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        place,
  input  logic [3:0]  cursor,
  output logic [17:0] board,
  output logic        player,
  output logic        busy,
  output logic        reject,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [3:0]  move_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [1:0]  CELL_EMPTY  = 2'b10;
  localparam logic [17:0] BOARD_EMPTY = {9{CELL_EMPTY}};

  logic [1:0]  state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        player_q, player_d;
  logic        busy_q, busy_d;
  logic        reject_q, reject_d;
  logic [1:0]  winner_q, winner_d;
  logic        over_q, over_d;
  logic [3:0]  mc_q, mc_d;
  logic [2:0]  line_q, line_d;

  logic [3:0] la, lb, lc;
  logic [3:0] cur_idx;
  logic       cursor_ok;
  logic [1:0] cur_cell;
  logic [1:0] sym;
  logic       line_match;

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

  always_comb begin
    la = 4'd0;
    lb = 4'd1;
    lc = 4'd2;
    case (line_q)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
  end

  // Out-of-range cursors are redirected to cell 0 so the select never leaves the board.
  assign cursor_ok  = (cursor <= 4'd8);
  assign cur_idx    = cursor_ok ? cursor : 4'd0;
  assign cur_cell   = cell_of(board_q, cur_idx);
  assign sym        = {1'b0, player_q};
  assign line_match = (cell_of(board_q, la) == sym) &&
                      (cell_of(board_q, lb) == sym) &&
                      (cell_of(board_q, lc) == sym);

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    player_d = player_q;
    busy_d   = busy_q;
    reject_d = 1'b0;
    winner_d = winner_q;
    over_d   = over_q;
    mc_d     = mc_q;
    line_d   = line_q;
    case (state_q)
      S_IDLE: begin
        if (place) begin
          if (cursor_ok && (cur_cell == CELL_EMPTY)) begin
            board_d[{cur_idx, 1'b0} +: 2] = sym;
            mc_d    = mc_q + 4'd1;
            line_d  = 3'd0;
            busy_d  = 1'b1;
            state_d = S_SCAN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (line_match) begin
          winner_d = player_q ? 2'b10 : 2'b01;
          over_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_OVER;
        end else if (line_q != 3'd7) begin
          line_d = line_q + 3'd1;
        end else if (mc_q == 4'd9) begin
          winner_d = 2'b11;
          over_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_OVER;
        end else begin
          player_d = ~player_q;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_OVER: begin
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      board_q  <= BOARD_EMPTY;
      player_q <= FIRST_PLAYER;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
      winner_q <= 2'b00;
      over_q   <= 1'b0;
      mc_q     <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      player_q <= player_d;
      busy_q   <= busy_d;
      reject_q <= reject_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      mc_q     <= mc_d;
      line_q   <= line_d;
    end
  end

  assign board      = board_q;
  assign player     = player_q;
  assign busy       = busy_q;
  assign reject     = reject_q;
  assign winner     = winner_q;
  assign game_over  = over_q;
  assign move_count = mc_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomised bench for game_turn_controller: a game-level reference model predicts
// each placement's outcome and latency; a negedge monitor checks them as they appear.
module tb_game_turn_controller;

  localparam logic FP = 1'b0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        place;
  logic [3:0]  cursor;
  logic [17:0] board;
  logic        player;
  logic        busy;
  logic        reject;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_count;

  game_turn_controller #(.FIRST_PLAYER(FP)) dut (
    .clk(clk), .resetn(resetn), .place(place), .cursor(cursor),
    .board(board), .player(player), .busy(busy), .reject(reject),
    .winner(winner), .game_over(game_over), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          e0;
    int          lat;
    logic        rej;
    logic [17:0] brd;
    logic        pl;
    logic [1:0]  win;
    logic        ov;
    logic [3:0]  mc;
  } exp_t;

  exp_t q[$];

  // Reference game state: 2 = empty, 0 = O, 1 = X
  int   m_brd [9];
  logic m_pl;
  logic [1:0] m_win;
  int   m_mc;
  bit   rst_hit;

  int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] m_board();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_brd[i]);
    return b;
  endfunction

  function automatic int first_win(input int p);
    for (int k = 0; k < 8; k++)
      if (m_brd[LN[k][0]] == p && m_brd[LN[k][1]] == p && m_brd[LN[k][2]] == p) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_brd[i] = 2;
    m_pl  = FP;
    m_win = 2'b00;
    m_mc  = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_board", board, {9{2'b10}});
    chk("rst_player", player, FP);
    chk("rst_busy", busy, 0);
    chk("rst_reject", reject, 0);
    chk("rst_winner", winner, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_move_count", move_count, 0);
  endtask

  // Monitor: any reject pulse or falling busy is one response from the DUT.
  exp_t e_mon;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      busy_prev = 1'b0;
    end else begin
      if (reject || (busy_prev && !busy)) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: reject=%b busy_fell=%b with nothing pending (cycle %0d)",
                   reject, busy_prev && !busy, cyc);
        end else begin
          e_mon = q.pop_front();
          chk("latency", cyc - e_mon.e0, e_mon.lat);
          chk("reject", reject, e_mon.rej);
          chk("busy", busy, 0);
          chk("board", board, e_mon.brd);
          chk("player", player, e_mon.pl);
          chk("winner", winner, e_mon.win);
          chk("game_over", game_over, e_mon.ov);
          chk("move_count", move_count, e_mon.mc);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    place  = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    resetn = 1'b1;
    q.delete();
    model_reset();
  endtask

  // rst_mode: 0 never, 1 occasionally, 2 always -- reset lands at E3 of a long scan.
  task automatic play(input int c, input int rst_mode);
    exp_t e;
    bit   valid;
    int   k;
    int   holds;
    bit   do_rst;
    rst_hit = 0;
    @(negedge clk);
    place  = 1'b1;
    cursor = 4'(c);
    if (m_win != 2'b00) begin
      @(negedge clk);
      place = 1'b0;
      repeat (3) @(negedge clk);
      chk("over_board", board, m_board());
      chk("over_winner", winner, m_win);
      chk("over_player", player, m_pl);
      chk("over_move_count", move_count, m_mc);
      chk("over_busy", busy, 0);
      return;
    end
    e.e0  = cyc + 1;
    valid = (c <= 8) && (m_brd[c] == 2);
    if (!valid) begin
      e.lat = 0;
      e.rej = 1'b1;
    end else begin
      e.rej = 1'b0;
      m_brd[c] = int'(m_pl);
      m_mc++;
      k = first_win(int'(m_pl));
      if (k >= 0) begin
        e.lat = k + 1;
        m_win = m_pl ? 2'b10 : 2'b01;
      end else begin
        e.lat = 8;
        if (m_mc == 9) m_win = 2'b11;
        else m_pl = ~m_pl;
      end
    end
    e.brd = m_board();
    e.pl  = m_pl;
    e.win = m_win;
    e.ov  = (m_win != 2'b00);
    e.mc  = 4'(m_mc);
    q.push_back(e);
    @(negedge clk);
    place  = 1'b0;
    do_rst = valid && (e.lat > 3) &&
             ((rst_mode == 2) || (rst_mode == 1 && $urandom_range(0, 19) == 0));
    if (valid) chk("busy_after_accept", busy, 1);
    if (do_rst) begin
      while (cyc < e.e0 + 2) @(negedge clk);
      resetn = 1'b0;
      q.delete();
      @(negedge clk);
      check_reset_state();
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      rst_hit = 1;
      return;
    end
    if (valid) begin
      holds = $urandom_range(0, 3);
      for (int h = 0; h < holds; h++) begin
        place  = 1'b1;
        cursor = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      place = 1'b0;
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL response_timeout: %0d responses outstanding after 20 cycles", q.size());
      q.delete();
    end
  endtask

  int seq4 [5] = '{0, 3, 1, 4, 2};
  int seq5 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    int c;
    int empties[$];
    resetn = 1'b0;
    place  = 1'b0;
    cursor = 4'd0;
    model_reset();
    do_reset();

    play(4, 0);
    play(4, 0);
    play(9, 0);
    do_reset();
    play(9, 0);
    play(15, 0);

    do_reset();
    foreach (seq4[i]) play(seq4[i], 0);
    play(8, 0);

    do_reset();
    foreach (seq5[i]) play(seq5[i], 0);
    play(0, 0);

    do_reset();
    play(0, 2);
    play(0, 0);

    for (int g = 0; g < 40; g++) begin
      do_reset();
      for (int m = 0; m < 30; m++) begin
        if (m_win != 2'b00) begin
          play($urandom_range(0, 15), 0);
          break;
        end
        if ($urandom_range(0, 3) == 0) begin
          c = $urandom_range(0, 15);
        end else begin
          empties.delete();
          for (int i = 0; i < 9; i++) if (m_brd[i] == 2) empties.push_back(i);
          c = empties[$urandom_range(0, empties.size() - 1)];
        end
        play(c, 1);
        if (rst_hit) break;
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
